// File: rtl/stepper_motor_pkg.sv
// Shared FSM encoding and arithmetic width rules for the stepper step generator.
package stepper_motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC_V = 3'd1,
        ST_CALC_X = 3'd2,
        ST_SETUP  = 3'd3,
        ST_PULSE  = 3'd4,
        ST_HOLD   = 3'd5
    } stepper_state_e;

    // Velocity + acceleration sum carries two guard bits above the wider magnitude.
    function automatic int unsigned sat_sum_width(input int unsigned v_width,
                                                  input int unsigned a_width);
        return ((v_width > a_width) ? v_width : a_width) + 2;
    endfunction

    function automatic int unsigned timer_width(input int unsigned pulse_width,
                                                input int unsigned dir_setup);
        return $clog2(((pulse_width > dir_setup) ? pulse_width : dir_setup) + 1);
    endfunction

endpackage

// File: rtl/stepper_motor_pulse_timer.sv
// Loadable down-counter; done_c is high once the count has drained to zero.
module stepper_motor_pulse_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cke,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (cke) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/stepper_motor_step_generator.sv
// Integrates acceleration into velocity and position on each update tick and emits
// direction-qualified step pulses whenever the integer part of the position changes.
module stepper_motor_step_generator
    import stepper_motor_pkg::*;
#(
    parameter int unsigned X_WIDTH     = 48,
    parameter int unsigned V_WIDTH     = 16,
    parameter int unsigned A_WIDTH     = 16,
    parameter int unsigned Q_WIDTH     = 16,
    parameter int unsigned PULSE_WIDTH = 8,
    parameter int unsigned DIR_SETUP   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cke,
    input  logic                      enable,
    input  logic signed [A_WIDTH:0]   s_a,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      update,
    input  logic [V_WIDTH-1:0]        max_v,
    input  logic signed [X_WIDTH-1:0] set_x,
    input  logic                      set_x_valid,
    output logic signed [X_WIDTH-1:0] cur_x,
    output logic signed [V_WIDTH:0]   cur_v,
    output logic                      step,
    output logic                      dir,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned S_WIDTH = sat_sum_width(V_WIDTH, A_WIDTH);
    localparam int unsigned T_WIDTH = timer_width(PULSE_WIDTH, DIR_SETUP);
    localparam logic [T_WIDTH-1:0] PULSE_LOAD = T_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [T_WIDTH-1:0] SETUP_LOAD = T_WIDTH'(DIR_SETUP - 1);

    stepper_state_e            state;
    logic signed [A_WIDTH:0]   acc_a;
    logic signed [S_WIDTH-1:0] v_sum_c;
    logic signed [S_WIDTH-1:0] v_lim_c;
    logic signed [S_WIDTH-1:0] v_sat_c;
    logic signed [X_WIDTH-1:0] x_next_c;
    logic                      step_req_c;
    logic                      dir_req_c;
    logic                      dir_change_c;
    logic                      timer_load_c;
    logic [T_WIDTH-1:0]        timer_value_c;
    logic                      timer_done_c;

    assign s_ready = 1'b1;

    // Saturating velocity update; disabled motion forces zero velocity.
    always_comb begin
        v_sum_c = S_WIDTH'(cur_v) + S_WIDTH'(acc_a);
        v_lim_c = S_WIDTH'({1'b0, max_v});
        v_sat_c = v_sum_c;
        if (!enable) begin
            v_sat_c = '0;
        end else if (v_sum_c > v_lim_c) begin
            v_sat_c = v_lim_c;
        end else if (v_sum_c < -v_lim_c) begin
            v_sat_c = -v_lim_c;
        end
    end

    // A step is due when the integer part of the position moves.
    assign x_next_c     = cur_x + X_WIDTH'(cur_v);
    assign step_req_c   = (x_next_c[X_WIDTH-1:Q_WIDTH] != cur_x[X_WIDTH-1:Q_WIDTH]);
    assign dir_req_c    = cur_v[V_WIDTH];
    assign dir_change_c = (dir_req_c != dir);

    // Timer is armed on the same edge the FSM enters SETUP, PULSE or HOLD.
    always_comb begin
        timer_load_c  = 1'b0;
        timer_value_c = PULSE_LOAD;
        case (state)
            ST_CALC_X: begin
                timer_load_c  = step_req_c;
                timer_value_c = dir_change_c ? SETUP_LOAD : PULSE_LOAD;
            end
            ST_SETUP, ST_PULSE: timer_load_c = timer_done_c;
            default: ;
        endcase
    end

    stepper_motor_pulse_timer #(
        .WIDTH (T_WIDTH)
    ) u_pulse_timer (
        .clk        (clk),
        .reset      (reset),
        .cke        (cke),
        .load       (timer_load_c),
        .load_value (timer_value_c),
        .done_c     (timer_done_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc_a   <= '0;
            cur_x   <= '0;
            cur_v   <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else if (cke) begin
            if (s_valid) begin
                acc_a <= s_a;
            end
            if (update && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (set_x_valid) begin
                        cur_x <= set_x;
                    end
                    if (update) begin
                        state <= ST_CALC_V;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC_V: begin
                    cur_v <= (V_WIDTH + 1)'(v_sat_c);
                    state <= ST_CALC_X;
                end
                ST_CALC_X: begin
                    cur_x <= x_next_c;
                    if (!step_req_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (dir_change_c) begin
                        dir   <= dir_req_c;
                        state <= ST_SETUP;
                    end else begin
                        step  <= 1'b1;
                        state <= ST_PULSE;
                    end
                end
                ST_SETUP: begin
                    if (timer_done_c) begin
                        step  <= 1'b1;
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (timer_done_c) begin
                        step  <= 1'b0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_done_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    step  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
